execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 16-bit pipelined CPU. It latches decoded operands and control bits in the decode/execute pipeline register and runs the 16-bit ALU. It also splits operand B into an address/data path and a store-data path. The selected result and the pass-through control bits are then latched in the execute/memory pipeline register for the memory stage.

## Interface
Parameters: none (data width fixed at 16, ALU opcode fixed at 3 bits).

Ports:
- clk  in  1  rising-edge clock for both pipeline registers
- rst  in  1  synchronous, active-high reset of both pipeline registers
- wbs_in  in  1  write-back select (decode stage)
- wme_in  in  1  write-memory-enable (decode stage)
- mm_in  in  2  memory mode (decode stage)
- ALUop_in  in  3  ALU opcode (decode stage)
- wm_in  in  1  write mode (decode stage)
- am_in  in  1  access mode; steers srcB (decode stage)
- ni_in  in  1  next-instruction flag (decode stage)
- srcA_in  in  16  operand A (decode stage)
- srcB_in  in  16  operand B (decode stage)
- sel_mux  in  1  execute-stage result select, combinational, not registered
- alu_result_ex  out  16  combinational ALU result of the execute-stage instruction
- flagN  out  1  negative flag, combinational: alu_result_ex[15]
- flagZ  out  1  zero flag, combinational: alu_result_ex == 0
- wbs_mem, wme_mem, wm_mem, ni_mem  out  1 each  control bits in the memory stage
- mm_mem  out  2  memory mode in the memory stage
- ALUresult_mem  out  16  registered execute result
- memData_mem  out  16  registered store data

## Operation
- D/E register: on each clk edge it captures all *_in signals into execute-stage copies (wbs_ex, wme_ex, mm_ex, ALUop_ex, wm_ex, am_ex, ni_ex, srcA_ex, srcB_ex).
- ALU, combinational on ALUop_ex, srcA_ex and srcB_ex. All arithmetic is modulo 2^16 and carry is discarded.
  - 000: pass B
  - 001: A+B
  - 010: A−B
  - 011: A&B
  - 100: A|B
  - 101: A^B
  - 110: A<<B[3:0]
  - 111: A>>B[3:0], logical
- Operand B split, combinational:
  - am_ex=0: addr_data = srcB_ex, store_data = 0
  - am_ex=1: addr_data = 0, store_data = srcB_ex
- Result mux: ex_result = sel_mux ? addr_data : alu_result_ex.
- E/M register: on each clk edge it captures the following:
  - wbs_ex, wme_ex, mm_ex, wm_ex and ni_ex into the matching *_mem outputs
  - ex_result into ALUresult_mem
  - store_data into memData_mem
  - ALUop_ex and am_ex are consumed in the execute stage and are not forwarded.
- There is no stall, enable or flush; both registers load every cycle.

## Timing
- Latency from inputs to alu_result_ex and flags is 1 edge: the inputs are captured at edge k and the result is valid after edge k.
- Latency from inputs to the *_mem outputs is 2 edges (k+1).
- Throughput is one instruction per cycle. The two registers form a 2-deep shift pipeline, and consecutive instructions never interact.
- sel_mux is sampled at edge k+1 together with the execute-stage instruction. It is not delayed with that instruction.
- Reset:
  - When rst=1 at an edge, both registers load all-zero. rst takes priority over capture.
  - After reset: every *_mem output is 0 and the D/E copies are 0.
  - alu_result_ex is therefore 0 (op 000, pass B=0), flagZ=1 and flagN=0.
- Reset asserted mid-stream discards both in-flight instructions at that edge. Inputs presented in the reset cycle are lost.
- flagN and flagZ follow alu_result_ex only. They do not reflect the sel_mux choice.

## Test plan
- ADD: ALUop=001, A=0x0002, B=0x0003, am=0, wbs=1, wme=1, mm=01, wm=1, ni=1, sel_mux=0.
  - After edge 1: alu_result_ex=0x0005, N=0, Z=0.
  - After edge 2: ALUresult_mem=0x0005, memData_mem=0, wbs/wme/wm/ni_mem=1, mm_mem=01.
- AND with store path: ALUop=011, A=0x0050, B=0x0007, am=1, sel_mux=0.
  - alu_result_ex=0x0000, Z=1.
  - One edge later: ALUresult_mem=0x0000, memData_mem=0x0007.
- Mux select: ALUop=100, A=0x0001, B=0x001F, am=0, sel_mux=1.
  - alu_result_ex=0x001F.
  - ALUresult_mem=0x001F taken from the srcB path, memData_mem=0.
  - Repeat with A=0x0020: alu_result_ex=0x003F, and ALUresult_mem is still 0x001F.
- SUB underflow: ALUop=010, A=0x0002, B=0x0003 gives 0xFFFF, N=1, Z=0.
- Shifts:
  - ALUop=110, A=0x0001, B=0x0013 gives 0x0008 (only B[3:0] used).
  - ALUop=111, A=0x8000, B=0x000F gives 0x0001.
- Back-to-back plus reset: issue three different instructions on consecutive edges and check each appears at *_mem exactly 2 edges after issue. Then assert rst for one edge mid-stream and check all *_mem=0, alu_result_ex=0, Z=1 after that edge.

Source files
------------

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage of the 16-bit pipelined CPU. The decode/execute register
//   captures the decoded operands and control bits. The 16-bit ALU then works
//   on the captured values, and operand B is split into an address/data path
//   and a store-data path. The selected result and the pass-through control
//   bits are captured in the execute/memory register.
//
// Ports
//   clk, rst          : rising-edge clock; synchronous active-high reset that
//                       clears both pipeline registers
//   *_in              : decode-stage control bits and operands
//   sel_mux           : result select for the instruction currently in execute
//                       (1 = srcB address/data path, 0 = ALU); not registered
//   alu_result_ex     : combinational ALU result of the execute instruction
//   flagN, flagZ      : negative / zero flags of alu_result_ex
//   *_mem             : memory-stage control bits, result and store data
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_in,
  input  logic        wme_in,
  input  logic [1:0]  mm_in,
  input  logic [2:0]  ALUop_in,
  input  logic        wm_in,
  input  logic        am_in,
  input  logic        ni_in,
  input  logic [15:0] srcA_in,
  input  logic [15:0] srcB_in,
  input  logic        sel_mux,
  output logic [15:0] alu_result_ex,
  output logic        flagN,
  output logic        flagZ,
  output logic        wbs_mem,
  output logic        wme_mem,
  output logic        wm_mem,
  output logic        ni_mem,
  output logic [1:0]  mm_mem,
  output logic [15:0] ALUresult_mem,
  output logic [15:0] memData_mem
);

  logic        wbs_ex;
  logic        wme_ex;
  logic [1:0]  mm_ex;
  logic [2:0]  ALUop_ex;
  logic        wm_ex;
  logic        am_ex;
  logic        ni_ex;
  logic [15:0] srcA_ex;
  logic [15:0] srcB_ex;

  logic [15:0] addr_data;
  logic [15:0] store_data;
  logic [15:0] ex_result;

  // All arithmetic wraps modulo 2^16. Shifts use only the low nibble of B.
  function automatic logic [15:0] alu_op(input logic [2:0]  op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [15:0] r;
    case (op)
      3'b000:  r = b;
      3'b001:  r = a + b;
      3'b010:  r = a - b;
      3'b011:  r = a & b;
      3'b100:  r = a | b;
      3'b101:  r = a ^ b;
      3'b110:  r = a << b[3:0];
      default: r = a >> b[3:0];
    endcase
    return r;
  endfunction

  // ---- decode/execute register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ex   <= 1'b0;
      wme_ex   <= 1'b0;
      mm_ex    <= 2'b00;
      ALUop_ex <= 3'b000;
      wm_ex    <= 1'b0;
      am_ex    <= 1'b0;
      ni_ex    <= 1'b0;
      srcA_ex  <= 16'h0000;
      srcB_ex  <= 16'h0000;
    end else begin
      wbs_ex   <= wbs_in;
      wme_ex   <= wme_in;
      mm_ex    <= mm_in;
      ALUop_ex <= ALUop_in;
      wm_ex    <= wm_in;
      am_ex    <= am_in;
      ni_ex    <= ni_in;
      srcA_ex  <= srcA_in;
      srcB_ex  <= srcB_in;
    end
  end

  // ---- execute: ALU, operand-B split, result select ----
  assign alu_result_ex = alu_op(ALUop_ex, srcA_ex, srcB_ex);
  assign flagN         = alu_result_ex[15];
  assign flagZ         = (alu_result_ex == 16'h0000);

  // The access mode routes srcB to exactly one of the two paths. The other
  // path is forced to zero.
  assign addr_data  = am_ex ? 16'h0000 : srcB_ex;
  assign store_data = am_ex ? srcB_ex  : 16'h0000;
  assign ex_result  = sel_mux ? addr_data : alu_result_ex;

  // ---- execute/memory register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_mem       <= 1'b0;
      wme_mem       <= 1'b0;
      mm_mem        <= 2'b00;
      wm_mem        <= 1'b0;
      ni_mem        <= 1'b0;
      ALUresult_mem <= 16'h0000;
      memData_mem   <= 16'h0000;
    end else begin
      wbs_mem       <= wbs_ex;
      wme_mem       <= wme_ex;
      mm_mem        <= mm_ex;
      wm_mem        <= wm_ex;
      ni_mem        <= ni_ex;
      ALUresult_mem <= ex_result;
      memData_mem   <= store_data;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Self-checking bench for execute_stage: directed vector table, hand-written
//   back-to-back/reset sequence and randomized pipelined stimulus checked
//   against a behavioural model.
// -----------------------------------------------------------------------------
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbs_in, wme_in, wm_in, am_in, ni_in, sel_mux;
  logic [1:0]  mm_in;
  logic [2:0]  ALUop_in;
  logic [15:0] srcA_in, srcB_in;
  logic [15:0] alu_result_ex, ALUresult_mem, memData_mem;
  logic        flagN, flagZ, wbs_mem, wme_mem, wm_mem, ni_mem;
  logic [1:0]  mm_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
    .wm_in(wm_in), .am_in(am_in), .ni_in(ni_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in), .sel_mux(sel_mux),
    .alu_result_ex(alu_result_ex), .flagN(flagN), .flagZ(flagZ),
    .wbs_mem(wbs_mem), .wme_mem(wme_mem), .wm_mem(wm_mem), .ni_mem(ni_mem),
    .mm_mem(mm_mem), .ALUresult_mem(ALUresult_mem), .memData_mem(memData_mem)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        am;
    logic        wbs;
    logic        wme;
    logic [1:0]  mm;
    logic        wm;
    logic        ni;
  } instr_t;

  typedef struct {
    instr_t      i;
    logic        sel;
    logic [15:0] e_alu;
    logic        e_n;
    logic        e_z;
    logic [15:0] e_res;
    logic [15:0] e_md;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [15:0] md;
    logic [5:0]  ctrl;
  } mem_t;

  instr_t zero_i;
  instr_t ex_m;
  mem_t   mem_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the opcode table, using wide integer arithmetic.
  function automatic logic [15:0] ref_alu(input instr_t i);
    longint a, b, p, r;
    a = longint'(i.a);
    b = longint'(i.b);
    p = 64'd1 << (b % 16);
    case (i.op)
      3'd0: r = b;
      3'd1: r = (a + b) % 65536;
      3'd2: r = (a - b + 65536) % 65536;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (a * p) % 65536;
      default: r = a / p;
    endcase
    return r[15:0];
  endfunction

  task automatic drive(input instr_t i);
    ALUop_in = i.op; srcA_in = i.a; srcB_in = i.b; am_in = i.am;
    wbs_in = i.wbs; wme_in = i.wme; mm_in = i.mm; wm_in = i.wm; ni_in = i.ni;
  endtask

  // Isolated instruction: issue, check execute outputs, then check memory outputs.
  task automatic apply_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    drive(v.i);
    rst = 1'b0;
    sel_mux = 1'b0;
    @(posedge clk); #1;
    drive(zero_i);
    chk({s, "_alu"}, {16'h0, alu_result_ex}, {16'h0, v.e_alu});
    chk({s, "_N"}, {31'h0, flagN}, {31'h0, v.e_n});
    chk({s, "_Z"}, {31'h0, flagZ}, {31'h0, v.e_z});
    sel_mux = v.sel;
    @(posedge clk); #1;
    chk({s, "_res_mem"}, {16'h0, ALUresult_mem}, {16'h0, v.e_res});
    chk({s, "_md_mem"}, {16'h0, memData_mem}, {16'h0, v.e_md});
    chk({s, "_ctrl_mem"}, {26'h0, wbs_mem, wme_mem, mm_mem, wm_mem, ni_mem},
        {26'h0, v.i.wbs, v.i.wme, v.i.mm, v.i.wm, v.i.ni});
  endtask

  // One pipelined cycle checked against the model. s selects the result of
  // the instruction currently in execute. r resets both stages.
  task automatic cycle(input instr_t i, input logic s, input logic r, input string tag);
    logic [15:0] ea;
    drive(i);
    sel_mux = s;
    rst = r;
    @(posedge clk);
    if (r) begin
      mem_m = '{res: 16'h0, md: 16'h0, ctrl: 6'h0};
      ex_m  = zero_i;
    end else begin
      mem_m.res  = s ? (ex_m.am ? 16'h0 : ex_m.b) : ref_alu(ex_m);
      mem_m.md   = ex_m.am ? ex_m.b : 16'h0;
      mem_m.ctrl = {ex_m.wbs, ex_m.wme, ex_m.mm, ex_m.wm, ex_m.ni};
      ex_m = i;
    end
    #1;
    rst = 1'b0;
    ea = ref_alu(ex_m);
    chk({tag, "_alu"}, {16'h0, alu_result_ex}, {16'h0, ea});
    chk({tag, "_N"}, {31'h0, flagN}, {31'h0, ea[15]});
    chk({tag, "_Z"}, {31'h0, flagZ}, {31'h0, (ea == 16'h0)});
    chk({tag, "_res_mem"}, {16'h0, ALUresult_mem}, {16'h0, mem_m.res});
    chk({tag, "_md_mem"}, {16'h0, memData_mem}, {16'h0, mem_m.md});
    chk({tag, "_ctrl_mem"}, {26'h0, wbs_mem, wme_mem, mm_mem, wm_mem, ni_mem},
        {26'h0, mem_m.ctrl});
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i.op  = 3'($urandom_range(0, 7));
    i.a   = 16'($urandom);
    i.b   = 16'($urandom);
    i.am  = 1'($urandom);
    i.wbs = 1'($urandom);
    i.wme = 1'($urandom);
    i.mm  = 2'($urandom);
    i.wm  = 1'($urandom);
    i.ni  = 1'($urandom);
    return i;
  endfunction

  vec_t   vecs [9];
  instr_t i1, i2, i3;

  initial begin
    zero_i = '{op: 3'd0, a: 16'h0, b: 16'h0, am: 1'b0, wbs: 1'b0, wme: 1'b0,
               mm: 2'd0, wm: 1'b0, ni: 1'b0};
    //                 op     a         b         am    wbs   wme   mm     wm    ni      sel   alu       N     Z     res       md
    vecs[0] = '{'{3'd1, 16'h0002, 16'h0003, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1}, 1'b0, 16'h0005, 1'b0, 1'b0, 16'h0005, 16'h0000};
    vecs[1] = '{'{3'd3, 16'h0050, 16'h0007, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0007};
    vecs[2] = '{'{3'd4, 16'h0001, 16'h001F, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1}, 1'b1, 16'h001F, 1'b0, 1'b0, 16'h001F, 16'h0000};
    vecs[3] = '{'{3'd4, 16'h0020, 16'h001F, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0}, 1'b1, 16'h003F, 1'b0, 1'b0, 16'h001F, 16'h0000};
    vecs[4] = '{'{3'd2, 16'h0002, 16'h0003, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0}, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0000};
    vecs[5] = '{'{3'd6, 16'h0001, 16'h0013, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1}, 1'b0, 16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0000};
    vecs[6] = '{'{3'd7, 16'h8000, 16'h000F, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0}, 1'b0, 16'h0001, 1'b0, 1'b0, 16'h0001, 16'h0000};
    vecs[7] = '{'{3'd0, 16'h1234, 16'hABCD, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1}, 1'b1, 16'hABCD, 1'b1, 1'b0, 16'h0000, 16'hABCD};
    vecs[8] = '{'{3'd5, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1}, 1'b1, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000};

    // Reset state
    drive(zero_i);
    sel_mux = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu", {16'h0, alu_result_ex}, 32'h0);
    chk("rst_Z", {31'h0, flagZ}, 32'h1);
    chk("rst_N", {31'h0, flagN}, 32'h0);
    chk("rst_res_mem", {16'h0, ALUresult_mem}, 32'h0);
    chk("rst_md_mem", {16'h0, memData_mem}, 32'h0);
    chk("rst_ctrl_mem", {26'h0, wbs_mem, wme_mem, mm_mem, wm_mem, ni_mem}, 32'h0);
    rst = 1'b0;

    // Directed table
    for (int k = 0; k < 9; k++) apply_vec(vecs[k], k);

    // Sync the model with a reset, then run back-to-back plus mid-stream reset.
    cycle(zero_i, 1'b0, 1'b1, "sync");
    i1 = '{op: 3'd1, a: 16'h1000, b: 16'h0234, am: 1'b0, wbs: 1'b1, wme: 1'b0, mm: 2'd1, wm: 1'b0, ni: 1'b1};
    i2 = '{op: 3'd2, a: 16'h0010, b: 16'h0020, am: 1'b1, wbs: 1'b0, wme: 1'b1, mm: 2'd2, wm: 1'b1, ni: 1'b0};
    i3 = '{op: 3'd5, a: 16'h00FF, b: 16'h0F0F, am: 1'b0, wbs: 1'b1, wme: 1'b1, mm: 2'd3, wm: 1'b1, ni: 1'b1};
    cycle(i1, 1'b0, 1'b0, "b2b_1");
    cycle(i2, 1'b0, 1'b0, "b2b_2");
    cycle(i3, 1'b0, 1'b0, "b2b_3");
    cycle(i1, 1'b1, 1'b0, "b2b_4");
    cycle(i2, 1'b0, 1'b1, "midrst");
    chk("midrst_res_mem", {16'h0, ALUresult_mem}, 32'h0);
    chk("midrst_alu", {16'h0, alu_result_ex}, 32'h0);
    chk("midrst_Z", {31'h0, flagZ}, 32'h1);
    cycle(i3, 1'b0, 1'b0, "post_rst");

    // Randomized pipelined stimulus with occasional resets
    for (int n = 0; n < 400; n++)
      cycle(rand_instr(), 1'($urandom), ($urandom_range(0, 19) == 0), "rnd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
